// File: rtl/vend_controller.sv
// Vending machine sequencer: collects coin credit, checks selections against price and stock,
// runs the dispense handshake, then returns change one coin per cycle.
module vend_controller #(
   parameter int NUM_SLOTS  = 4,
   parameter int PRICE      = 3,
   parameter int STOCK_INIT = 3,
   parameter int CREDIT_W   = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [1:0]           in,
   input  logic                 sel_valid,
   input  logic [1:0]           sel_slot,
   output logic                 disp_req,
   output logic [1:0]           disp_slot,
   input  logic                 disp_ack,
   output logic [1:0]           change,
   output logic [CREDIT_W-1:0]  credit,
   output logic                 busy,
   output logic [NUM_SLOTS-1:0] sold_out,
   output logic                 err_credit,
   output logic                 err_empty,
   output logic                 coin_rej,
   output logic [1:0]           dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DISPENSE = 2'd1,
      S_CHANGE   = 2'd2
   } state_e;

   localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
   localparam logic [3:0]          STOCK_INIT_C = 4'(STOCK_INIT);

   state_e                state_q, state_d;
   logic [CREDIT_W-1:0]   credit_q, credit_d;
   logic [3:0]            stock_q [NUM_SLOTS];
   logic [3:0]            stock_d [NUM_SLOTS];
   logic [1:0]            disp_slot_q, disp_slot_d;
   logic                  err_credit_q, err_credit_d;
   logic                  err_empty_q, err_empty_d;
   logic                  coin_rej_q, coin_rej_d;

   logic [1:0]            coin_units;
   logic [1:0]            pay_units;
   logic [CREDIT_W-1:0]   base_credit;
   logic [CREDIT_W:0]     coin_sum;

   // Change coin size depends only on registered credit, so it is shared by both comb processes.
   assign pay_units = (credit_q >= CREDIT_W'(2)) ? 2'd2 : 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         credit_q     <= '0;
         disp_slot_q  <= 2'd0;
         err_credit_q <= 1'b0;
         err_empty_q  <= 1'b0;
         coin_rej_q   <= 1'b0;
         for (int i = 0; i < NUM_SLOTS; i++) stock_q[i] <= STOCK_INIT_C;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         disp_slot_q  <= disp_slot_d;
         err_credit_q <= err_credit_d;
         err_empty_q  <= err_empty_d;
         coin_rej_q   <= coin_rej_d;
         for (int i = 0; i < NUM_SLOTS; i++) stock_q[i] <= stock_d[i];
      end
   end

   always_comb begin
      state_d      = state_q;
      credit_d     = credit_q;
      stock_d      = stock_q;
      disp_slot_d  = disp_slot_q;
      err_credit_d = 1'b0;
      err_empty_d  = 1'b0;
      coin_rej_d   = 1'b0;
      coin_units   = 2'd0;
      base_credit  = credit_q;
      coin_sum     = '0;
      unique case (state_q)
         S_IDLE: begin
            if (in == 2'd1)      coin_units = 2'd1;
            else if (in == 2'd2) coin_units = 2'd2;
            // Selection is judged on pre-coin credit; a same-cycle coin lands on top of the result.
            if (sel_valid) begin
               if (stock_q[sel_slot] == 4'd0) begin
                  err_empty_d = 1'b1;
               end else if (credit_q < PRICE_C) begin
                  err_credit_d = 1'b1;
               end else begin
                  base_credit       = credit_q - PRICE_C;
                  stock_d[sel_slot] = stock_q[sel_slot] - 4'd1;
                  disp_slot_d       = sel_slot;
                  state_d           = S_DISPENSE;
               end
            end else if ((in == 2'd3) && (credit_q != '0)) begin
               state_d = S_CHANGE;
            end
            coin_sum = {1'b0, base_credit} + (CREDIT_W+1)'(coin_units);
            if (coin_sum[CREDIT_W]) coin_rej_d = 1'b1;
            else                    credit_d   = coin_sum[CREDIT_W-1:0];
         end
         S_DISPENSE: begin
            if (disp_ack) state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
         end
         S_CHANGE: begin
            credit_d = credit_q - CREDIT_W'(pay_units);
            if (credit_q == CREDIT_W'(pay_units)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      disp_req    = (state_q == S_DISPENSE);
      disp_slot   = disp_slot_q;
      change      = (state_q == S_CHANGE) ? pay_units : 2'd0;
      credit      = credit_q;
      busy        = (state_q != S_IDLE);
      err_credit  = err_credit_q;
      err_empty   = err_empty_q;
      coin_rej    = coin_rej_q;
      dbg_state_o = state_q;
      for (int i = 0; i < NUM_SLOTS; i++) sold_out[i] = (stock_q[i] == 4'd0);
   end

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: per-cycle expected outputs from a transaction-level model are
// queued at drive time and popped by an independent monitor just after each clock edge.
module tb_vend_controller;
  localparam int W          = 18;
  localparam int PRICE      = 3;
  localparam int STOCK_INIT = 3;
  localparam int MAX_CREDIT = 31;

  localparam int M_IDLE   = 0;
  localparam int M_VEND   = 1;
  localparam int M_REFUND = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_slot = 2'd0;
  logic       disp_ack = 1'b0;
  logic       disp_req;
  logic [1:0] disp_slot;
  logic [1:0] change;
  logic [4:0] credit;
  logic       busy;
  logic [3:0] sold_out;
  logic       err_credit;
  logic       err_empty;
  logic       coin_rej;
  logic [1:0] dbg_state;

  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: a customer-visible view of the machine.
  int m_mode;
  int m_credit;
  int m_stock[4];
  int m_slot;
  bit m_ec, m_ee, m_cr;

  always #5 clk = ~clk;

  vend_controller dut (
    .clk(clk), .rst(rst), .in(in), .sel_valid(sel_valid), .sel_slot(sel_slot),
    .disp_req(disp_req), .disp_slot(disp_slot), .disp_ack(disp_ack), .change(change),
    .credit(credit), .busy(busy), .sold_out(sold_out), .err_credit(err_credit),
    .err_empty(err_empty), .coin_rej(coin_rej), .dbg_state_o(dbg_state)
  );

  task automatic model_step(input logic r, input logic [1:0] c, input logic sv,
                            input logic [1:0] ss, input logic ack);
    int coin;
    int spend;
    int nxt;
    m_ec = 0; m_ee = 0; m_cr = 0;
    if (r) begin
      m_mode = M_IDLE; m_credit = 0; m_slot = 0;
      for (int i = 0; i < 4; i++) m_stock[i] = STOCK_INIT;
      return;
    end
    nxt = m_mode;
    if (m_mode == M_IDLE) begin
      coin  = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : 0;
      spend = 0;
      if (sv) begin
        if (m_stock[ss] == 0) m_ee = 1;
        else if (m_credit < PRICE) m_ec = 1;
        else begin
          spend = PRICE;
          m_stock[ss] = m_stock[ss] - 1;
          m_slot = int'(ss);
          nxt = M_VEND;
        end
      end else if (c == 2'd3 && m_credit > 0) begin
        nxt = M_REFUND;
      end
      if (m_credit - spend + coin > MAX_CREDIT) m_cr = 1;
      else m_credit = m_credit - spend + coin;
    end else if (m_mode == M_VEND) begin
      if (ack) nxt = (m_credit > 0) ? M_REFUND : M_IDLE;
    end else begin
      m_credit = m_credit - ((m_credit >= 2) ? 2 : 1);
      if (m_credit == 0) nxt = M_IDLE;
    end
    m_mode = nxt;
  endtask

  function automatic logic [W-1:0] model_outputs();
    logic [3:0] so;
    logic [1:0] ch;
    for (int i = 0; i < 4; i++) so[i] = (m_stock[i] == 0);
    ch = (m_mode == M_REFUND) ? ((m_credit >= 2) ? 2'd2 : 2'd1) : 2'd0;
    return {(m_mode == M_VEND), 2'(m_slot), ch, 5'(m_credit), (m_mode != M_IDLE), so,
            m_ec, m_ee, m_cr};
  endfunction

  task automatic drive(input logic r, input logic [1:0] c, input logic sv,
                       input logic [1:0] ss, input logic ack);
    @(negedge clk);
    rst = r; in = c; sel_valid = sv; sel_slot = ss; disp_ack = ack;
    model_step(r, c, sv, ss, ack);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic coin(input logic [1:0] c);
    drive(1'b0, c, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic select(input logic [1:0] s);
    drive(1'b0, 2'd0, 1'b1, s, 1'b0);
  endtask

  task automatic ack();
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
  endtask

  // Monitor: one comparison of the full output set per clock.
  always @(posedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {disp_req, disp_slot, change, credit, busy, sold_out, err_credit, err_empty, coin_rej};
      compared++;
      if (act_v !== exp_v) begin
        mismatched++;
        $display("FAIL outputs @%0t: got %b required %b (req,slot,change,credit,busy,sold_out,ec,ee,rej) state=%0d",
                 $time, act_v, exp_v, dbg_state);
      end
    end
  end

  initial begin
    logic [1:0] c;
    // Reset
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    idle(1);
    // Overpay with change
    coin(2'd2); coin(2'd2); select(2'd1); idle(3); ack(); idle(3);
    // Exact pay, no change
    coin(2'd1); coin(2'd1); coin(2'd1); select(2'd0); idle(1); ack(); idle(2);
    // Short credit then cancel
    coin(2'd2); select(2'd2); idle(1); coin(2'd3); idle(2);
    // Drain slot 2, then select it empty
    for (int k = 0; k < 3; k++) begin
      coin(2'd2); coin(2'd1); select(2'd2); idle(1); ack(); idle(1);
    end
    coin(2'd2); coin(2'd2); coin(2'd2); select(2'd2); idle(2);
    // Selection beats cancel; coin with selection
    drive(1'b0, 2'd3, 1'b1, 2'd1, 1'b0); ack(); idle(4);
    coin(2'd2); drive(1'b0, 2'd2, 1'b1, 2'd3, 1'b0); idle(1); ack(); idle(4);
    // Reset mid-dispense
    coin(2'd2); coin(2'd2); select(2'd3); idle(1);
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0); idle(2);
    // Credit overflow at the top of range
    for (int k = 0; k < 15; k++) coin(2'd2);
    coin(2'd1); coin(2'd1); coin(2'd2); coin(2'd1);
    coin(2'd3); idle(18);
    // Randomized traffic, including inputs while busy and stray acks
    for (int k = 0; k < 3000; k++) begin
      c = 2'($urandom_range(0, 3));
      if (c == 2'd3 && $urandom_range(0, 3) != 0) c = 2'd1;
      drive(($urandom_range(0, 249) == 0), c, ($urandom_range(0, 5) == 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0));
    end
    idle(3);
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
